mem_req_ctrl: RTL and testbench
===============================

MEM_REQ_CTRL -- requirements
Module: mem_req_ctrl

Interface
REQ-001 Parameter ADDR_W, default 4, SHALL set the word address width, matching the 16-entry memory.
REQ-002 Parameter DATA_W, default 8, SHALL set the data width.
REQ-003 Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1, SHALL be the reset; synchronous, active-high.
REQ-005 Ports req_valid (in, 1), req_ready (out, 1), req_we (in, 1), req_adr (in, ADDR_W) and req_wdata (in, DATA_W) SHALL form the request channel.
REQ-006 Ports rsp_valid (out, 1), rsp_ready (in, 1) and rsp_rdata (out, DATA_W) SHALL form the read-response channel.
REQ-007 Ports mem_adr (out, ADDR_W), mem_we (out, 1), mem_dat_w (out, DATA_W) and mem_dat_r (in, DATA_W) SHALL connect to the downstream memory; that memory has a registered read address, so read data appears one cycle after the address.
REQ-008 Ports rd_count (out, 8) and wr_count (out, 8) SHALL count completed reads and writes.

Function
REQ-009 The block SHALL implement a three-state FSM with states IDLE, CAPTURE and RESP.
REQ-010 req_ready SHALL be 1 only in IDLE; a request is accepted on a cycle where req_valid=1 and req_ready=1.
REQ-011 mem_adr SHALL equal req_adr and mem_dat_w SHALL equal req_wdata combinationally in every state.
REQ-012 mem_we SHALL be exactly req_valid & req_ready & req_we, with no other write path.
REQ-013 Accepted write: the memory SHALL be written in the accept cycle, the FSM SHALL stay in IDLE, wr_count SHALL increment, and no response is generated.
REQ-014 Back-to-back writes SHALL sustain one write per cycle.
REQ-015 Accepted read: the FSM SHALL move IDLE->CAPTURE.
REQ-016 In CAPTURE, the block SHALL register mem_dat_r into rsp_rdata, set rsp_valid=1 and move to RESP.
REQ-017 Read latency SHALL be 2 cycles, from the accept edge to the first cycle with rsp_valid=1.
REQ-018 In RESP, rsp_valid and rsp_rdata SHALL hold stable until rsp_ready=1.
REQ-019 On the RESP cycle where rsp_ready=1, rd_count SHALL increment, rsp_valid SHALL clear at the next edge, and the FSM SHALL return to IDLE.
REQ-020 A read SHALL therefore occupy at least 3 cycles; no new request is accepted until the FSM is back in IDLE.
REQ-021 rsp_ready asserted outside RESP SHALL be ignored.
REQ-022 rsp_rdata SHALL keep its last value when rsp_valid=0.
REQ-023 rd_count and wr_count SHALL wrap from 255 to 0 without saturation.
REQ-024 Addresses 0 and 2**ADDR_W-1 SHALL need no special handling; req_adr is passed through unmodified.
REQ-025 The block SHALL not drive or inspect req_wdata on reads, nor mem_dat_r outside CAPTURE.

Reset
REQ-026 When rst=1 at a clock edge, the FSM SHALL enter IDLE and rsp_valid, rsp_rdata, rd_count and wr_count SHALL become 0.
REQ-027 While rst=1, req_ready SHALL be 0 and mem_we SHALL be 0.
REQ-028 A read in flight (CAPTURE or RESP) when reset asserts SHALL be discarded, with no response and no rd_count increment.
REQ-029 In the first cycle after rst deasserts, the block SHALL be in IDLE with req_ready=1.

Structure
REQ-030 The FSM state enum (IDLE, CAPTURE, RESP), ADDR_W/DATA_W defaults and the counter width (8) SHALL live in a shared package, mem_pkg.
REQ-031 The block SHALL be a single module with no sub-modules; the memory is instantiated alongside it at the next level up, not inside it.

Verification
REQ-032 Write then read: write adr=0x3, data=0xA5; read adr=0x3 -> rsp_rdata=0xA5 two cycles after read accept; wr_count=1, rd_count=1.
REQ-033 Back-to-back writes: write adr 0x0..0xF with data=adr^0xFF on 16 consecutive cycles -> req_ready stays 1 and wr_count=16; reading adr 0xF returns 0xF0.
REQ-034 Backpressure: read adr=0x3 (holding 0xA5) with rsp_ready=0 for 5 cycles -> rsp_valid=1 with rsp_rdata=0xA5 stable and req_ready=0 throughout; asserting rsp_ready returns the FSM to IDLE next cycle.
REQ-035 Reset mid-read: accept read, pulse rst in CAPTURE -> rsp_valid=0, rd_count=0, req_ready=1 the cycle after rst deasserts.
REQ-036 Counter wrap: 256 writes -> wr_count=0; one more write -> wr_count=1.
REQ-037 Write ignored while busy: with the FSM in RESP, hold req_valid=1, req_we=1 -> mem_we stays 0 until the FSM returns to IDLE.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and defaults for the memory request controller.
// The FSM encoding, default widths and counter width live here.
package mem_pkg;

    localparam int unsigned AddrWDefault = 4;
    localparam int unsigned DataWDefault = 8;
    localparam int unsigned CntW         = 8;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StCapture = 2'd1,
        StResp    = 2'd2
    } state_e;

    // Modulo-256 increment; counters wrap rather than saturate.
    function automatic logic [CntW-1:0] cnt_inc(input logic [CntW-1:0] cnt);
        return cnt + CntW'(1);
    endfunction

endpackage

// File: rtl/mem_req_ctrl.sv
// Request/response front end for a 16-entry memory with a registered read address.
// Writes complete in the accept cycle; reads capture memory data and hold it until taken.
module mem_req_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W = AddrWDefault,
    parameter int unsigned DATA_W = DataWDefault
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_adr,
    input  logic [DATA_W-1:0] req_wdata,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,

    output logic [ADDR_W-1:0] mem_adr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_dat_w,
    input  logic [DATA_W-1:0] mem_dat_r,

    output logic [CntW-1:0]   rd_count,
    output logic [CntW-1:0]   wr_count
);

    state_e              state_q, state_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [CntW-1:0]     rd_count_q, rd_count_d;
    logic [CntW-1:0]     wr_count_q, wr_count_d;
    logic                accept;

    // Ready is gated by reset so nothing is accepted or written while rst is high.
    assign req_ready = (state_q == StIdle) && !rst;
    assign accept    = req_valid && req_ready;

    assign mem_adr   = req_adr;
    assign mem_dat_w = req_wdata;
    assign mem_we    = accept && req_we;

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rd_count  = rd_count_q;
    assign wr_count  = wr_count_q;

    always_comb begin
        state_d     = state_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rd_count_d  = rd_count_q;
        wr_count_d  = wr_count_q;

        if (mem_we) begin
            wr_count_d = cnt_inc(wr_count_q);
        end

        unique case (state_q)
            StIdle: begin
                if (accept && !req_we) begin
                    state_d = StCapture;
                end
            end
            // Memory read data is valid this cycle, one cycle after the address was accepted.
            StCapture: begin
                rsp_rdata_d = mem_dat_r;
                rsp_valid_d = 1'b1;
                state_d     = StResp;
            end
            StResp: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rd_count_d  = cnt_inc(rd_count_q);
                    state_d     = StIdle;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                state_d     = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rd_count_q  <= '0;
            wr_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rd_count_q  <= rd_count_d;
            wr_count_q  <= wr_count_d;
        end
    end

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Self-checking bench for mem_req_ctrl with a behavioural registered-address memory.
// Read data expectations come from a shadow memory and flow through a scoreboard queue.
module tb_mem_req_ctrl;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DATA_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid, req_ready, req_we;
    logic [ADDR_W-1:0] req_adr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid, rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic [ADDR_W-1:0] mem_adr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_dat_w, mem_dat_r;
    logic [7:0]        rd_count, wr_count;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] sh_mem [16];
    logic [DATA_W-1:0] exp_q [$];
    logic [7:0]        exp_rd, exp_wr;
    logic [DATA_W-1:0] last_rdata;

    logic [DATA_W-1:0] mem [16];
    logic [ADDR_W-1:0] mem_rd_adr_q;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) mem[mem_adr] <= mem_dat_w;
        mem_rd_adr_q <= mem_adr;
    end
    assign mem_dat_r = mem[mem_rd_adr_q];

    mem_req_ctrl #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_adr   (req_adr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .mem_adr   (mem_adr),
        .mem_we    (mem_we),
        .mem_dat_w (mem_dat_w),
        .mem_dat_r (mem_dat_r),
        .rd_count  (rd_count),
        .wr_count  (wr_count)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_counts(input string name);
        checks++;
        if (rd_count !== exp_rd || wr_count !== exp_wr) begin
            errors++;
            $display("FAIL %s: rd_count=%0d wr_count=%0d, required rd=%0d wr=%0d",
                     name, rd_count, wr_count, exp_rd, exp_wr);
        end
    endtask

    // One accepted write beat; leaves req_valid asserted for back-to-back use.
    task automatic write_beat(input logic [3:0] adr, input logic [7:0] data);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_adr   = adr;
        req_wdata = data;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || mem_we !== 1'b1 || mem_adr !== adr || mem_dat_w !== data) begin
            errors++;
            $display("FAIL write_beat adr=%h: ready=%b we=%b adr=%h dat=%h, required 1 1 %h %h",
                     adr, req_ready, mem_we, mem_adr, mem_dat_w, adr, data);
        end
        sh_mem[adr] = data;
        exp_wr++;
        next_cycle();
    endtask

    task automatic go_idle();
        req_valid = 1'b0;
        req_we    = 1'b0;
    endtask

    // Accept a read, check 2-cycle latency, hold off rsp_ready for 'hold' cycles, then take it.
    task automatic do_read(input logic [3:0] adr, input int hold);
        int                lat;
        logic [DATA_W-1:0] held;
        logic [DATA_W-1:0] exp;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_adr   = adr;
        req_wdata = 8'($urandom);
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL read_accept adr=%h: ready=%b we=%b, required 1 0", adr, req_ready, mem_we);
        end
        exp_q.push_back(sh_mem[adr]);
        next_cycle();
        req_valid = 1'b0;
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 6) begin
            next_cycle();
            lat++;
        end
        checks++;
        if (lat != 2) begin
            errors++;
            $display("FAIL read_latency adr=%h: %0d cycles, required 2", adr, lat);
        end
        held = rsp_rdata;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== held || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL backpressure cyc=%0d: valid=%b rdata=%h ready=%b, required 1 %h 0",
                         i, rsp_valid, rsp_rdata, req_ready, held);
            end
            next_cycle();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        exp = exp_q.pop_front();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== exp) begin
            errors++;
            $display("FAIL read_data adr=%h: valid=%b rdata=%h, required 1 %h",
                     adr, rsp_valid, rsp_rdata, exp);
        end
        next_cycle();
        rsp_ready = 1'b0;
        exp_rd++;
        last_rdata = exp;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL read_done adr=%h: valid=%b ready=%b, required 0 1",
                     adr, rsp_valid, req_ready);
        end
        check_counts("read_counts");
    endtask

    task automatic do_reset();
        rst = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b0;
        exp_rd = 8'd0;
        exp_wr = 8'd0;
        last_rdata = '0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_adr   = 4'h7;
        req_wdata = 8'h3C;
        rsp_ready = 1'b0;
        next_cycle();
        next_cycle();
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b0 || mem_we !== 1'b0 || rsp_valid !== 1'b0 || rsp_rdata !== 8'h00) begin
            errors++;
            $display("FAIL reset_hold: ready=%b we=%b valid=%b rdata=%h, required 0 0 0 00",
                     req_ready, mem_we, rsp_valid, rsp_rdata);
        end
        exp_rd = 8'd0;
        exp_wr = 8'd0;
        check_counts("reset_counts");
        next_cycle();
        go_idle();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: ready=%b, required 1", req_ready);
        end
        next_cycle();
    endtask

    task automatic test_write_read();
        write_beat(4'h3, 8'hA5);
        go_idle();
        check_counts("wr_after_write");
        do_read(4'h3, 0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 16; i++) begin
            write_beat(4'(i), 8'(i) ^ 8'hFF);
        end
        go_idle();
        check_counts("b2b_counts");
        do_read(4'hF, 0);
        do_read(4'h0, 0);
    endtask

    task automatic test_backpressure();
        write_beat(4'h3, 8'hA5);
        go_idle();
        do_read(4'h3, 5);
    endtask

    task automatic test_ignore_rsp_ready();
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            checks++;
            if (rsp_valid !== 1'b0 || rsp_rdata !== last_rdata || req_ready !== 1'b1) begin
                errors++;
                $display("FAIL idle_rsp_ready: valid=%b rdata=%h ready=%b, required 0 %h 1",
                         rsp_valid, rsp_rdata, req_ready, last_rdata);
            end
        end
        rsp_ready = 1'b0;
        check_counts("idle_rsp_ready_counts");
    endtask

    task automatic test_busy_write();
        logic [DATA_W-1:0] exp;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_adr   = 4'h9;
        @(negedge clk);
        exp_q.push_back(sh_mem[4'h9]);
        next_cycle();
        next_cycle();
        req_we    = 1'b1;
        req_adr   = 4'h5;
        req_wdata = 8'h5A;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (mem_we !== 1'b0 || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL busy_write cyc=%0d: we=%b ready=%b, required 0 0", i, mem_we, req_ready);
            end
            next_cycle();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        exp = exp_q.pop_front();
        checks++;
        if (mem_we !== 1'b0 || rsp_rdata !== exp) begin
            errors++;
            $display("FAIL busy_release: we=%b rdata=%h, required 0 %h", mem_we, rsp_rdata, exp);
        end
        next_cycle();
        rsp_ready = 1'b0;
        exp_rd++;
        @(negedge clk);
        checks++;
        if (mem_we !== 1'b1 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL busy_then_idle: we=%b ready=%b, required 1 1", mem_we, req_ready);
        end
        sh_mem[4'h5] = 8'h5A;
        exp_wr++;
        next_cycle();
        go_idle();
        check_counts("busy_counts");
        do_read(4'h5, 1);
    endtask

    task automatic test_reset_mid_read();
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_adr   = 4'h3;
        next_cycle();
        go_idle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        exp_rd = 8'd0;
        exp_wr = 8'd0;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_rdata !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid_read: valid=%b ready=%b rdata=%h, required 0 1 00",
                     rsp_valid, req_ready, rsp_rdata);
        end
        check_counts("reset_mid_read_counts");
        next_cycle();
        next_cycle();
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_read_late: valid=%b, required 0", rsp_valid);
        end
        last_rdata = '0;
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 256; i++) begin
            write_beat(4'(i), 8'(i));
        end
        go_idle();
        checks++;
        if (wr_count !== 8'd0) begin
            errors++;
            $display("FAIL wr_wrap: wr_count=%0d, required 0", wr_count);
        end
        write_beat(4'h1, 8'h77);
        go_idle();
        checks++;
        if (wr_count !== 8'd1) begin
            errors++;
            $display("FAIL wr_wrap_plus1: wr_count=%0d, required 1", wr_count);
        end
        do_read(4'h1, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_adr    = '0;
        req_wdata  = '0;
        rsp_ready  = 1'b0;
        exp_rd     = 8'd0;
        exp_wr     = 8'd0;
        last_rdata = '0;
        #1;
        test_reset();
        test_write_read();
        test_back_to_back();
        test_backpressure();
        test_ignore_rsp_ready();
        test_busy_write();
        test_reset_mid_read();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
